issue_queue: RTL and testbench

//  Decoupling FIFO directly downstream of the issue manager. Captures each decoded instruction presented with
//  is_issueing, holds it in program order, and hands it to dispatch (ROB/RS allocation) via a valid/ready handshake.

---
 rtl/issue_queue_pkg.sv | 31 +++
 rtl/issue_queue_storage.sv | 25 ++
 rtl/issue_queue.sv | 152 +++++++++++++++
 tb/tb_issue_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: payload width, field offsets used for
// pack/unpack, and the opcode constants that dispatch also decodes.
package issue_queue_pkg;

    localparam int ISSUE_PAYLOAD_W = 167;

    // Bit offsets of each field inside the stored payload word (LSB first).
    localparam int PC_LSB     = 0;    // 32 bits
    localparam int PRED_LSB   = 32;   // 32 bits
    localparam int INS_LSB    = 64;   // 32 bits
    localparam int OPC_LSB    = 96;   // 7 bits
    localparam int F3_LSB     = 103;  // 3 bits
    localparam int F7_LSB     = 106;  // 7 bits
    localparam int IMM_LSB    = 113;  // 32 bits
    localparam int SHAMT_LSB  = 145;  // 6 bits
    localparam int RS1_LSB    = 151;  // 5 bits
    localparam int RS2_LSB    = 156;  // 5 bits
    localparam int RD_LSB     = 161;  // 5 bits
    localparam int RVC_LSB    = 166;  // 1 bit

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/issue_queue_storage.sv
// Payload register array for the issue queue: one synchronous write port,
// one asynchronous read port, no reset (contents are qualified by the pointers).
module issue_queue_storage #(
    parameter int DEPTH = 16,
    parameter int W     = 167
) (
    input  logic                     clk_in,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/issue_queue.sv
// In-order decoupling FIFO between the issue manager and dispatch.
// Optional zero-latency empty-queue bypass is enabled by defining ISSUE_QUEUE_BYPASS_EN.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int SKID_SLOTS = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        is_issueing,
    input  logic [31:0] issue_PC,
    input  logic [31:0] predicted_resulting_PC,
    input  logic [31:0] full_ins,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm_val,
    input  logic [5:0]  shamt_val,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        is_compressed_ins,
    output logic        issue_space_available,
    output logic        dispatch_valid,
    input  logic        dispatch_ready,
    output logic [31:0] dispatch_issue_PC,
    output logic [31:0] dispatch_predicted_resulting_PC,
    output logic [31:0] dispatch_full_ins,
    output logic [6:0]  dispatch_opcode,
    output logic [2:0]  dispatch_funct3,
    output logic [6:0]  dispatch_funct7,
    output logic [31:0] dispatch_imm_val,
    output logic [5:0]  dispatch_shamt_val,
    output logic [4:0]  dispatch_rs1,
    output logic [4:0]  dispatch_rs2,
    output logic [4:0]  dispatch_rd,
    output logic        dispatch_is_compressed_ins,
    output logic        overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic [CNT_W-1:0]           count;
    logic [ISSUE_PAYLOAD_W-1:0] in_payload;
    logic [ISSUE_PAYLOAD_W-1:0] mem_payload;
    logic [ISSUE_PAYLOAD_W-1:0] head_payload;
    logic                       full;
    logic                       empty;
    logic                       bypass_live;
    logic                       bypass_take;
    logic                       wr_en;
    logic                       pop;
    logic [CNT_W:0]             space_sum;

    always_comb begin
        in_payload = '0;
        in_payload[PC_LSB    +: 32] = issue_PC;
        in_payload[PRED_LSB  +: 32] = predicted_resulting_PC;
        in_payload[INS_LSB   +: 32] = full_ins;
        in_payload[OPC_LSB   +: 7]  = opcode;
        in_payload[F3_LSB    +: 3]  = funct3;
        in_payload[F7_LSB    +: 7]  = funct7;
        in_payload[IMM_LSB   +: 32] = imm_val;
        in_payload[SHAMT_LSB +: 6]  = shamt_val;
        in_payload[RS1_LSB   +: 5]  = rs1;
        in_payload[RS2_LSB   +: 5]  = rs2;
        in_payload[RD_LSB    +: 5]  = rd;
        in_payload[RVC_LSB]         = is_compressed_ins;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

`ifdef ISSUE_QUEUE_BYPASS_EN
    assign bypass_live = empty & is_issueing & ~flush_pipline;
`else
    assign bypass_live = 1'b0;
`endif

    // Dispatch handshake: dispatch_valid is asserted whenever a head entry is
    // presented, independent of dispatch_ready; an entry transfers on any cycle
    // where both are high (and rdy_in is high), and dispatch_* stay stable while
    // dispatch_valid is high and dispatch_ready is low.
    assign dispatch_valid = (~empty & ~flush_pipline) | bypass_live;
    assign head_payload   = bypass_live ? in_payload : mem_payload;
    assign bypass_take    = bypass_live & dispatch_ready;

    // Full-queue enqueues are dropped even when a pop frees a slot this cycle.
    assign wr_en = rdy_in & ~flush_pipline & is_issueing & ~full & ~bypass_take;
    assign pop   = rdy_in & ~flush_pipline & dispatch_valid & dispatch_ready & ~empty;

    assign space_sum             = {1'b0, count} + (CNT_W+1)'(SKID_SLOTS);
    assign issue_space_available = (space_sum < (CNT_W+1)'(DEPTH)) & ~flush_pipline;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (rdy_in) begin
            if (is_issueing & full) begin
                overflow_err <= 1'b1;
            end
            if (flush_pipline) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (wr_en) begin
                    tail <= tail + PTR_W'(1);
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                count <= count + CNT_W'(wr_en) - CNT_W'(pop);
            end
        end
    end

    issue_queue_storage #(
        .DEPTH (DEPTH),
        .W     (ISSUE_PAYLOAD_W)
    ) u_storage (
        .clk_in  (clk_in),
        .wr_en   (wr_en),
        .wr_addr (tail),
        .wr_data (in_payload),
        .rd_addr (head),
        .rd_data (mem_payload)
    );

    assign dispatch_issue_PC               = head_payload[PC_LSB    +: 32];
    assign dispatch_predicted_resulting_PC = head_payload[PRED_LSB  +: 32];
    assign dispatch_full_ins               = head_payload[INS_LSB   +: 32];
    assign dispatch_opcode                 = head_payload[OPC_LSB   +: 7];
    assign dispatch_funct3                 = head_payload[F3_LSB    +: 3];
    assign dispatch_funct7                 = head_payload[F7_LSB    +: 7];
    assign dispatch_imm_val                = head_payload[IMM_LSB   +: 32];
    assign dispatch_shamt_val              = head_payload[SHAMT_LSB +: 6];
    assign dispatch_rs1                    = head_payload[RS1_LSB   +: 5];
    assign dispatch_rs2                    = head_payload[RS2_LSB   +: 5];
    assign dispatch_rd                     = head_payload[RD_LSB    +: 5];
    assign dispatch_is_compressed_ins      = head_payload[RVC_LSB];

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue (DEPTH=16, SKID_SLOTS=2): scoreboard of expected PCs,
// per-cycle reference checks plus hand-computed checkpoints for each scenario.
module tb_issue_queue;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        is_issueing;
    logic [31:0] issue_PC;
    logic [31:0] predicted_resulting_PC;
    logic [31:0] full_ins;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_val;
    logic [5:0]  shamt_val;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        is_compressed_ins;
    logic        issue_space_available;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [31:0] dispatch_issue_PC;
    logic [31:0] dispatch_predicted_resulting_PC;
    logic [31:0] dispatch_full_ins;
    logic [6:0]  dispatch_opcode;
    logic [2:0]  dispatch_funct3;
    logic [6:0]  dispatch_funct7;
    logic [31:0] dispatch_imm_val;
    logic [5:0]  dispatch_shamt_val;
    logic [4:0]  dispatch_rs1;
    logic [4:0]  dispatch_rs2;
    logic [4:0]  dispatch_rd;
    logic        dispatch_is_compressed_ins;
    logic        overflow_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    int          m_count  = 0;
    logic        m_ovf    = 1'b0;

    issue_queue #(.DEPTH(16), .SKID_SLOTS(2)) dut (
        .clk_in                          (clk_in),
        .rst_in                          (rst_in),
        .rdy_in                          (rdy_in),
        .flush_pipline                   (flush_pipline),
        .is_issueing                     (is_issueing),
        .issue_PC                        (issue_PC),
        .predicted_resulting_PC          (predicted_resulting_PC),
        .full_ins                        (full_ins),
        .opcode                          (opcode),
        .funct3                          (funct3),
        .funct7                          (funct7),
        .imm_val                         (imm_val),
        .shamt_val                       (shamt_val),
        .rs1                             (rs1),
        .rs2                             (rs2),
        .rd                              (rd),
        .is_compressed_ins               (is_compressed_ins),
        .issue_space_available           (issue_space_available),
        .dispatch_valid                  (dispatch_valid),
        .dispatch_ready                  (dispatch_ready),
        .dispatch_issue_PC               (dispatch_issue_PC),
        .dispatch_predicted_resulting_PC (dispatch_predicted_resulting_PC),
        .dispatch_full_ins               (dispatch_full_ins),
        .dispatch_opcode                 (dispatch_opcode),
        .dispatch_funct3                 (dispatch_funct3),
        .dispatch_funct7                 (dispatch_funct7),
        .dispatch_imm_val                (dispatch_imm_val),
        .dispatch_shamt_val              (dispatch_shamt_val),
        .dispatch_rs1                    (dispatch_rs1),
        .dispatch_rs2                    (dispatch_rs2),
        .dispatch_rd                     (dispatch_rd),
        .dispatch_is_compressed_ins      (dispatch_is_compressed_ins),
        .overflow_err                    (overflow_err)
    );

    // Clock and reset
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Every payload field is derived from the PC so any head can be fully predicted.
    task automatic set_payload(input logic [31:0] pc);
        issue_PC               = pc;
        predicted_resulting_PC = pc + 32'd4;
        full_ins               = pc ^ 32'h1234_5678;
        opcode                 = pc[8:2];
        funct3                 = pc[4:2];
        funct7                 = pc[10:4];
        imm_val                = ~pc;
        shamt_val              = pc[7:2];
        rs1                    = pc[6:2];
        rs2                    = pc[7:3];
        rd                     = pc[8:4];
        is_compressed_ins      = pc[2];
    endtask

    task automatic check_head(input logic [31:0] pc);
        check("head_pc",   dispatch_issue_PC, pc);
        check("head_pred", dispatch_predicted_resulting_PC, pc + 32'd4);
        check("head_ins",  dispatch_full_ins, pc ^ 32'h1234_5678);
        check("head_opc",  32'(dispatch_opcode), 32'(pc[8:2]));
        check("head_f7",   32'(dispatch_funct7), 32'(pc[10:4]));
        check("head_imm",  dispatch_imm_val, ~pc);
        check("head_sh",   32'(dispatch_shamt_val), 32'(pc[7:2]));
        check("head_rs2",  32'(dispatch_rs2), 32'(pc[7:3]));
        check("head_rd",   32'(dispatch_rd), 32'(pc[8:4]));
        check("head_rvc",  32'(dispatch_is_compressed_ins), 32'(pc[2]));
    endtask

    task automatic do_reset();
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        flush_pipline  = 1'b0;
        is_issueing    = 1'b0;
        dispatch_ready = 1'b0;
        set_payload(32'h0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    // One clock: drive strobes, check outputs against the reference, advance the model.
    task automatic cycle(input logic enq, input logic [31:0] pc, input logic rdy_d);
        logic bypass_now;
        int   c0;
        is_issueing    = enq;
        dispatch_ready = rdy_d;
        set_payload(pc);
        #2;
        bypass_now = 1'b0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        bypass_now = enq && (m_count == 0) && !flush_pipline;
`endif
        check("valid", 32'(dispatch_valid), 32'(((m_count != 0) || bypass_now) && !flush_pipline));
        check("space", 32'(issue_space_available), 32'((m_count + 2 < 16) && !flush_pipline));
        check("ovf", 32'(overflow_err), 32'(m_ovf));
        if (!flush_pipline) begin
            if (bypass_now) check_head(pc);
            else if (m_count != 0) check_head(exp_q[0]);
        end
        c0 = m_count;
        @(posedge clk_in);
        #1;
        if (rdy_in) begin
            if (enq && c0 == 16) m_ovf = 1'b1;
            if (flush_pipline) begin
                exp_q.delete();
                m_count = 0;
            end else begin
                if (rdy_d && c0 != 0) begin
                    void'(exp_q.pop_front());
                    m_count--;
                end
                if (enq && c0 < 16 && !(bypass_now && rdy_d)) begin
                    exp_q.push_back(pc);
                    m_count++;
                end
            end
        end
    endtask

    // Pops until the DUT reports empty (bounded) and checks how many entries it held.
    task automatic drain(input string tag, input int exp_n);
        int n;
        n = 0;
        while (dispatch_valid && n < 40) begin
            cycle(1'b0, 32'h0, 1'b1);
            n++;
        end
        check(tag, n, exp_n);
        check("drain_empty", 32'(dispatch_valid), 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_valid", 32'(dispatch_valid), 32'd0);
        check("rst_space", 32'(issue_space_available), 32'd1);
        check("rst_ovf",   32'(overflow_err), 32'd0);

        // Three enqueues with dispatch stalled
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(i * 4), 1'b0);
        check("t1_valid", 32'(dispatch_valid), 32'd1);
        check("t1_pc",    dispatch_issue_PC, 32'h0);

        // Fill to 14: skid reservation closes the upstream window
        for (int i = 3; i < 13; i++) cycle(1'b1, 32'(i * 4), 1'b0);
        check("t2_space13", 32'(issue_space_available), 32'd1);
        cycle(1'b1, 32'd52, 1'b0);
        check("t2_space14", 32'(issue_space_available), 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        check("t2_space_back", 32'(issue_space_available), 32'd1);

        // Fill to 16, then enqueue into a full queue while popping
        for (int i = 14; i < 17; i++) cycle(1'b1, 32'(i * 4), 1'b0);
        check("t3_full_space", 32'(issue_space_available), 32'd0);
        check("t3_head_pre",   dispatch_issue_PC, 32'h4);
        cycle(1'b1, 32'hDEAD_0000, 1'b1);
        check("t3_ovf",        32'(overflow_err), 32'd1);
        check("t3_head_post",  dispatch_issue_PC, 32'h8);
        drain("t3_count15", 15);

        // Flush with 10 queued and both strobes active
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h200 + 32'(i * 4), 1'b0);
        flush_pipline = 1'b1;
        #1;
        check("t4_valid_flush", 32'(dispatch_valid), 32'd0);
        cycle(1'b1, 32'h300, 1'b1);
        flush_pipline = 1'b0;
        is_issueing   = 1'b0;
        #1;
        check("t4_valid_after", 32'(dispatch_valid), 32'd0);
        check("t4_ovf_kept",    32'(overflow_err), 32'd1);
        cycle(1'b1, 32'h400, 1'b0);
        check("t4_next_pc", dispatch_issue_PC, 32'h400);
        drain("t4_count1", 1);

        // Global stall freezes everything
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h500 + 32'(i * 4), 1'b0);
        rdy_in = 1'b0;
        repeat (5) cycle(1'b1, 32'h600, 1'b1);
        check("t5_head", dispatch_issue_PC, 32'h500);
        rdy_in = 1'b1;
        drain("t5_count4", 4);

        // Rate-1 stream through the pointer wrap
        for (int i = 0; i < 40; i++) cycle(1'b1, 32'h1000 + 32'(i * 4), 1'b1);
`ifdef ISSUE_QUEUE_BYPASS_EN
        drain("t6_left", 0);
`else
        check("t6_last", dispatch_issue_PC, 32'h109C);
        drain("t6_left", 1);
`endif

        // Reset mid-operation discards entries and clears the sticky flag
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h700 + 32'(i * 4), 1'b0);
        do_reset();
        check("rst2_valid", 32'(dispatch_valid), 32'd0);
        check("rst2_space", 32'(issue_space_available), 32'd1);
        check("rst2_ovf",   32'(overflow_err), 32'd0);

        // Empty-queue latency
        is_issueing = 1'b1;
        set_payload(32'h100);
        dispatch_ready = 1'b1;
        #1;
`ifdef ISSUE_QUEUE_BYPASS_EN
        check("t7_bp_valid", 32'(dispatch_valid), 32'd1);
        check("t7_bp_pc",    dispatch_issue_PC, 32'h100);
        cycle(1'b1, 32'h100, 1'b1);
        is_issueing = 1'b0;
        #1;
        check("t7_bp_empty", 32'(dispatch_valid), 32'd0);
`else
        check("t7_nobp_valid", 32'(dispatch_valid), 32'd0);
        cycle(1'b1, 32'h100, 1'b1);
        is_issueing = 1'b0;
        #1;
        check("t7_next_valid", 32'(dispatch_valid), 32'd1);
        check("t7_next_pc",    dispatch_issue_PC, 32'h100);
        drain("t7_count1", 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
